// File: rtl/packed_acc_unpacker_if.sv
// Handshake bundle between the accumulator source, the unpacker and the
// activation write-back path. The master side is the one that feeds
// accumulator words in and drains packed words out.
interface packed_acc_unpacker_if #(
    parameter int SHIFT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_mode;
    logic [SHIFT_W-1:0] shift;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [2:0]         out_bytes;
    logic               sat;

    modport master (
        output in_valid, in_data, in_mode, shift, flush, out_ready,
        input  in_ready, out_valid, out_data, out_bytes, sat
    );

    modport slave (
        input  in_valid, in_data, in_mode, shift, flush, out_ready,
        output in_ready, out_valid, out_data, out_bytes, sat
    );
endinterface

// File: rtl/packed_acc_unpacker.sv
// Unpacks 32-bit accumulator words (one scalar lane or two packed signed
// lanes), requantizes each lane to int8 with round-half-up and arithmetic
// shift, and packs four result bytes per output word.
//
// state | meaning
// IDLE  | waiting for an accumulator word or a flush of a partial pack
// LANE0 | requantize lane 0 into byte cnt
// LANE1 | requantize lane 1 (upper half) into byte cnt
// OUT   | hold the packed word until the sink takes it
module packed_acc_unpacker #(
    parameter int LANE_W  = 12,
    parameter int SHIFT_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    packed_acc_unpacker_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic [31:0]        pack_q;
    logic [31:0]        data_q;
    logic               mode_q;
    logic [SHIFT_W-1:0] shift_q;
    // lane1 still owed after an early emit caused by a misaligned packed word
    logic               pend_q;
    logic               out_valid_q;
    logic               sat_q;

    logic               in_ready_c;
    logic signed [33:0] lane_v;
    logic signed [33:0] rnd_v;
    logic signed [33:0] sum_v;
    logic signed [33:0] res_v;
    logic [7:0]         lane_byte;
    logic               lane_clip;

    // Ready only while idle and not busy emitting a flushed partial word.
    assign in_ready_c    = !rst_i && (state_q == IDLE) && !(bus.flush && (cnt_q != 3'd0));
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = pack_q;
    assign bus.out_bytes = cnt_q;
    assign bus.sat       = sat_q;

    // Select the lane being processed and requantize it to a saturated byte.
    always_comb begin
        lane_v    = '0;
        rnd_v     = '0;
        sum_v     = '0;
        res_v     = '0;
        lane_byte = '0;
        lane_clip = 1'b0;

        if (state_q == LANE1) begin
            lane_v = {{(34-LANE_W){data_q[16+LANE_W-1]}}, data_q[16 +: LANE_W]};
        end else if (mode_q) begin
            lane_v = {{(34-LANE_W){data_q[LANE_W-1]}}, data_q[LANE_W-1:0]};
        end else begin
            lane_v = {{2{data_q[31]}}, data_q};
        end

        if (shift_q != '0) begin
            rnd_v = 34'sd1 <<< (shift_q - {{(SHIFT_W-1){1'b0}}, 1'b1});
        end

        sum_v = lane_v + rnd_v;
        res_v = sum_v >>> shift_q;

        if (res_v > 34'sd127) begin
            lane_byte = 8'h7F;
            lane_clip = 1'b1;
        end else if (res_v < -34'sd128) begin
            lane_byte = 8'h80;
            lane_clip = 1'b1;
        end else begin
            lane_byte = res_v[7:0];
        end
    end

    // Sequencer: capture, per-lane byte write, and output hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            pack_q      <= 32'd0;
            data_q      <= 32'd0;
            mode_q      <= 1'b0;
            shift_q     <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_c) begin
                        data_q  <= bus.in_data;
                        mode_q  <= bus.in_mode;
                        shift_q <= bus.shift;
                        state_q <= LANE0;
                    end else if (bus.flush && (cnt_q != 3'd0)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                LANE0: begin
                    pack_q[{cnt_q[1:0], 3'b000} +: 8] <= lane_byte;
                    cnt_q <= cnt_q + 3'd1;
                    if (lane_clip) begin
                        sat_q <= 1'b1;
                    end
                    if (cnt_q == 3'd3) begin
                        pend_q      <= mode_q;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (mode_q) begin
                        state_q <= LANE1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LANE1: begin
                    pack_q[{cnt_q[1:0], 3'b000} +: 8] <= lane_byte;
                    cnt_q  <= cnt_q + 3'd1;
                    pend_q <= 1'b0;
                    if (lane_clip) begin
                        sat_q <= 1'b1;
                    end
                    if (cnt_q == 3'd3) begin
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        cnt_q       <= 3'd0;
                        pack_q      <= 32'd0;
                        out_valid_q <= 1'b0;
                        state_q     <= pend_q ? LANE1 : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
